a_master_port_prio: RTL and testbench

Parametrised arbiter-side master port for the serial bus; one instance per master between that master's 1-bit serial link and the arbiter controller. It deserialises a request frame carrying slave ID and priority, and presents it to the controller as a held request. It serialises grant and stop codes back to the master, and tracks slave ACK/NAK with a bounded timeout. It supports split (resume) and pre-empt stops, and re-requests automatically after a stop.

---
 rtl/a_master_port_prio_if.sv | 26 ++
 rtl/a_master_port_prio.sv | 233 +++++++++++++++++++++++
 tb/tb_a_master_port_prio.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/a_master_port_prio_if.sv
// rtl/a_master_port_prio_if.sv - serial link and controller signals of one arbiter master port
interface a_master_port_prio_if #(
    parameter int S_ID_WIDTH = 2,
    parameter int PRIO_WIDTH = 2
);
    logic                  port_in;
    logic                  port_out;
    logic [1:0]            cmd;
    logic                  req_valid;
    logic [S_ID_WIDTH-1:0] id;
    logic [PRIO_WIDTH-1:0] prio;
    logic [1:0]            com_state;
    logic                  done;

    // Port block side: receives the master's bits and controller commands.
    modport slave (
        input  port_in, cmd,
        output port_out, req_valid, id, prio, com_state, done
    );

    // Driver side: the master link and the arbiter controller together.
    modport master (
        output port_in, cmd,
        input  port_out, req_valid, id, prio, com_state, done
    );
endinterface

// File: rtl/a_master_port_prio.sv
// rtl/a_master_port_prio.sv - arbiter-side master port: request deserialiser, grant/stop serialiser, ACK tracking
module a_master_port_prio #(
    parameter int NO_SLAVES   = 3,
    parameter int S_ID_WIDTH  = $clog2(NO_SLAVES + 1),
    parameter int PRIO_WIDTH  = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rstN,
    a_master_port_prio_if.slave bus
);
    // Controller commands (00 = no command, ignored everywhere).
    localparam logic [1:0] CMD_STOP_S = 2'b01;
    localparam logic [1:0] CMD_STOP_P = 2'b10;
    localparam logic [1:0] CMD_CLEAR  = 2'b11;

    // Communication status reported to the controller.
    localparam logic [1:0] MC_END_COM  = 2'b00;
    localparam logic [1:0] MC_NAK      = 2'b01;
    localparam logic [1:0] MC_WAIT_ACK = 2'b10;
    localparam logic [1:0] MC_COM      = 2'b11;

    localparam int HDR_LEN = S_ID_WIDTH + PRIO_WIDTH;
    localparam int HCW     = $clog2(HDR_LEN + 1);
    localparam int TCW     = $clog2(ACK_TIMEOUT + 1);

    localparam logic [HCW-1:0] HDR_LAST = HCW'(HDR_LEN - 1);
    localparam logic [HCW-1:0] ID_BITS  = HCW'(S_ID_WIDTH);
    localparam logic [TCW-1:0] TO_LAST  = TCW'(ACK_TIMEOUT - 1);
    localparam logic [TCW-1:0] TO_MAX   = TCW'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RX_HDR = 3'd1,
        S_REQ    = 3'd2,
        S_ACK    = 3'd3,
        S_COM    = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_hist;
    logic [2:0]            w_hist_nxt;
    logic [HCW-1:0]        r_hdr_cnt;
    logic [S_ID_WIDTH-1:0] r_id;
    logic [PRIO_WIDTH-1:0] r_prio;
    logic [TCW-1:0]        r_to_cnt;
    logic                  r_split;
    logic [1:0]            r_com_state;
    logic                  r_done;
    logic                  r_port_out;
    logic [1:0]            r_tx_sh;
    logic [1:0]            r_tx_cnt;

    logic                  w_tx_busy;
    logic                  w_load;
    logic [2:0]            w_code;
    logic [1:0]            w_com_nxt;
    logic                  w_split_set;
    logic                  w_split_clr;
    logic                  w_id_clr;
    logic                  w_to_clr;
    logic                  w_done_nxt;

    // Pattern matching looks at the history including the bit arriving this edge,
    // so a response is taken on the same edge that samples its last bit.
    assign w_hist_nxt = {r_hist[1:0], bus.port_in};
    assign w_tx_busy  = (r_tx_cnt != 2'd0);

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode; code-loading transitions wait for the TX shifter to drain.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hist_nxt == 3'b111) w_state_nxt = S_RX_HDR;
            end
            S_RX_HDR: begin
                if (r_hdr_cnt == HDR_LAST) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (bus.cmd == CMD_CLEAR && !w_tx_busy) w_state_nxt = S_ACK;
            end
            S_ACK: begin
                if (w_hist_nxt == 3'b101) begin
                    if (!w_tx_busy) w_state_nxt = S_COM;
                end else if (w_hist_nxt == 3'b110 || r_to_cnt == TO_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_COM: begin
                if (w_hist_nxt[1:0] == 2'b01) begin
                    w_state_nxt = S_IDLE;
                end else if ((bus.cmd == CMD_STOP_S || bus.cmd == CMD_STOP_P) && !w_tx_busy) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_hist_nxt == 3'b010) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Transition actions: code loads, status updates, split flag and id clearing.
    always_comb begin
        w_load      = 1'b0;
        w_code      = 3'b000;
        w_com_nxt   = r_com_state;
        w_split_set = 1'b0;
        w_split_clr = 1'b0;
        w_id_clr    = 1'b0;
        w_to_clr    = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_REQ: begin
                if (w_state_nxt == S_ACK) begin
                    w_load    = 1'b1;
                    w_code    = r_split ? 3'b100 : 3'b110;
                    w_com_nxt = MC_WAIT_ACK;
                    w_to_clr  = 1'b1;
                end
            end
            S_ACK: begin
                if (w_state_nxt == S_COM) begin
                    w_load    = 1'b1;
                    w_code    = 3'b111;
                    w_com_nxt = MC_COM;
                end else if (w_state_nxt == S_IDLE) begin
                    w_com_nxt   = MC_NAK;
                    w_split_clr = 1'b1;
                    w_id_clr    = 1'b1;
                end
            end
            S_COM: begin
                if (w_state_nxt == S_IDLE) begin
                    w_com_nxt   = MC_END_COM;
                    w_split_clr = 1'b1;
                    w_id_clr    = 1'b1;
                end else if (w_state_nxt == S_HOLD) begin
                    w_load = 1'b1;
                    if (bus.cmd == CMD_STOP_S) begin
                        w_code      = 3'b010;
                        w_split_set = 1'b1;
                    end else begin
                        w_code      = 3'b011;
                        w_split_clr = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (w_state_nxt == S_REQ) w_done_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Input history; wiped on any state change so old bits never form a match.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)                     r_hist <= 3'b000;
        else if (w_state_nxt != r_state) r_hist <= 3'b000;
        else                           r_hist <= w_hist_nxt;
    end

    // Header capture: id bits first, then priority, both MSB first.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_hdr_cnt <= '0;
            r_id      <= '0;
            r_prio    <= '0;
        end else if (r_state == S_RX_HDR) begin
            r_hdr_cnt <= r_hdr_cnt + HCW'(1);
            if (r_hdr_cnt < ID_BITS) r_id   <= S_ID_WIDTH'({r_id, bus.port_in});
            else                     r_prio <= PRIO_WIDTH'({r_prio, bus.port_in});
        end else begin
            r_hdr_cnt <= '0;
            if (w_id_clr) r_id <= '0;
        end
    end

    // ACK timeout counter; saturates rather than wrapping.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)                                   r_to_cnt <= '0;
        else if (w_to_clr)                           r_to_cnt <= '0;
        else if (r_state == S_ACK && r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + TCW'(1);
    end

    // Status, split flag and stop-confirm pulse.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_com_state <= MC_END_COM;
            r_split     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_com_state <= w_com_nxt;
            r_done      <= w_done_nxt;
            if (w_split_set)      r_split <= 1'b1;
            else if (w_split_clr) r_split <= 1'b0;
        end
    end

    // TX shifter: MSB goes out the cycle after the load, then two more bits, then idle 0.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_port_out <= 1'b0;
            r_tx_sh    <= 2'b00;
            r_tx_cnt   <= 2'd0;
        end else if (w_load) begin
            r_port_out <= w_code[2];
            r_tx_sh    <= w_code[1:0];
            r_tx_cnt   <= 2'd2;
        end else if (w_tx_busy) begin
            r_port_out <= r_tx_sh[1];
            r_tx_sh    <= {r_tx_sh[0], 1'b0};
            r_tx_cnt   <= r_tx_cnt - 2'd1;
        end else begin
            r_port_out <= 1'b0;
        end
    end

    assign bus.port_out  = r_port_out;
    assign bus.req_valid = (r_state == S_REQ);
    assign bus.id        = r_id;
    assign bus.prio      = r_prio;
    assign bus.com_state = r_com_state;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_a_master_port_prio.sv
// tb/tb_a_master_port_prio.sv - scoreboard bench for a_master_port_prio
module tb_a_master_port_prio;
    localparam int EV_REQ  = 0;
    localparam int EV_COM  = 1;
    localparam int EV_DONE = 2;

    localparam logic [1:0] C_NONE = 2'b00, C_STOP_S = 2'b01, C_STOP_P = 2'b10, C_CLEAR = 2'b11;
    localparam logic [1:0] M_END = 2'b00, M_NAK = 2'b01, M_WAIT = 2'b10, M_COM = 2'b11;

    typedef struct { int kind; logic [7:0] val; int cyc; } ev_t;
    typedef struct { int start; int nbits; logic [2:0] code; } tx_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   started = 1'b0;
    ev_t  evq[$];
    tx_t  txq[$];
    logic       p_rv = 1'b0;
    logic [1:0] p_cs = 2'b00;

    a_master_port_prio_if #(.S_ID_WIDTH(2), .PRIO_WIDTH(2)) bus ();

    a_master_port_prio #(
        .NO_SLAVES(3), .PRIO_WIDTH(2), .ACK_TIMEOUT(16)
    ) dut (
        .clk(clk), .rstN(rstN), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1);
    end

    function automatic logic [7:0] com_v(input logic [1:0] cs, input logic [1:0] id);
        return {3'b000, cs, 1'b0, id};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_ev(input int kind, input logic [7:0] val, input int c);
        ev_t e;
        e.kind = kind; e.val = val; e.cyc = c;
        evq.push_back(e);
    endtask

    task automatic exp_tx(input int start, input int n, input logic [2:0] code);
        tx_t t;
        t.start = start; t.nbits = n; t.code = code;
        txq.push_back(t);
    endtask

    task automatic take(input int kind, input logic [7:0] v);
        ev_t e;
        tests++;
        if (evq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: kind %0d val %0h at cycle %0d, none expected", kind, v, cyc);
        end else begin
            e = evq.pop_front();
            if (e.kind != kind || e.val !== v || e.cyc != cyc) begin
                fails++;
                $display("FAIL event: got kind %0d val %0h cycle %0d, want kind %0d val %0h cycle %0d",
                         kind, v, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    task automatic mon_step();
        logic exp_bit;
        int   idx;
        exp_bit = 1'b0;
        if (txq.size() > 0 && cyc >= txq[0].start) begin
            idx = cyc - txq[0].start;
            exp_bit = txq[0].code[2-idx];
            if (idx >= txq[0].nbits - 1) void'(txq.pop_front());
        end
        check("port_out", {31'b0, bus.port_out}, {31'b0, exp_bit});
        if (bus.done) take(EV_DONE, 8'h00);
        if (bus.req_valid && !p_rv) take(EV_REQ, {4'b0000, bus.id, bus.prio});
        if (bus.com_state != p_cs) take(EV_COM, {3'b000, bus.com_state, bus.req_valid, bus.id});
        p_rv = bus.req_valid;
        p_cs = bus.com_state;
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (started) mon_step();
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.port_in = bits[i];
            @(negedge clk);
        end
        bus.port_in = 1'b0;
    endtask

    task automatic req(input logic [1:0] id, input logic [1:0] pr);
        int k;
        k = cyc;
        exp_ev(EV_REQ, {4'b0000, id, pr}, k + 7);
        send({1'b0, 3'b111, id, pr}, 7);
    endtask

    task automatic clear(input logic [2:0] code, input logic [1:0] id);
        int k;
        k = cyc;
        exp_tx(k + 1, 3, code);
        exp_ev(EV_COM, com_v(M_WAIT, id), k + 1);
        bus.cmd = C_CLEAR;
        step();
        bus.cmd = C_NONE;
    endtask

    task automatic grant(input logic [1:0] id);
        int k;
        steps(2);
        k = cyc;
        exp_ev(EV_COM, com_v(M_COM, id), k + 3);
        exp_tx(k + 3, 3, 3'b111);
        send(8'b101, 3);
        steps(3);
    endtask

    task automatic nak();
        int k;
        k = cyc;
        exp_ev(EV_COM, com_v(M_NAK, 2'd0), k + 3);
        send(8'b110, 3);
    endtask

    task automatic end_com();
        int k;
        k = cyc;
        exp_ev(EV_COM, com_v(M_END, 2'd0), k + 2);
        send(8'b01, 2);
    endtask

    task automatic stop(input logic [1:0] c, input logic [2:0] code);
        int k;
        k = cyc;
        exp_tx(k + 1, 3, code);
        bus.cmd = c;
        step();
        bus.cmd = C_NONE;
    endtask

    task automatic resume(input logic [1:0] id, input logic [1:0] pr);
        int k;
        steps(3);
        k = cyc;
        exp_ev(EV_DONE, 8'h00, k + 3);
        exp_ev(EV_REQ, {4'b0000, id, pr}, k + 3);
        send(8'b010, 3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_port_out"},  {31'b0, bus.port_out}, 32'd0);
        check({tag, "_req_valid"}, {31'b0, bus.req_valid}, 32'd0);
        check({tag, "_id"},        {30'b0, bus.id}, 32'd0);
        check({tag, "_prio"},      {30'b0, bus.prio}, 32'd0);
        check({tag, "_com_state"}, {30'b0, bus.com_state}, {30'b0, M_END});
        check({tag, "_done"},      {31'b0, bus.done}, 32'd0);
    endtask

    initial begin
        int k;
        bus.port_in = 1'b0;
        bus.cmd     = C_NONE;
        rstN        = 1'b0;
        steps(2);
        check_reset_outputs("reset");
        rstN    = 1'b1;
        started = 1'b1;
        step();

        // Basic request, grant and master end.
        req(2'd2, 2'd1);
        clear(3'b110, 2'd2);
        grant(2'd2);
        end_com();

        // NAK from the slave.
        req(2'd3, 2'd2);
        clear(3'b110, 2'd3);
        steps(2);
        nak();

        // No answer: forced NAK 16 cycles after ACK entry.
        req(2'd1, 2'd3);
        k = cyc;
        clear(3'b110, 2'd1);
        exp_ev(EV_COM, com_v(M_NAK, 2'd0), k + 1 + 16);
        steps(20);

        // Split stop, resume, then pre-empt stop and simultaneous end/stop.
        req(2'd2, 2'd1);
        clear(3'b110, 2'd2);
        grant(2'd2);
        stop(C_STOP_S, 3'b010);
        resume(2'd2, 2'd1);
        clear(3'b100, 2'd2);
        grant(2'd2);
        stop(C_STOP_P, 3'b011);
        resume(2'd2, 2'd1);
        clear(3'b110, 2'd2);
        grant(2'd2);
        k = cyc;
        exp_ev(EV_COM, com_v(M_END, 2'd0), k + 2);
        bus.port_in = 1'b0;
        step();
        bus.port_in = 1'b1;
        bus.cmd     = C_STOP_S;
        step();
        bus.port_in = 1'b0;
        bus.cmd     = C_NONE;
        steps(4);

        // Asynchronous reset during the second bit of the 111 grant code.
        req(2'd3, 2'd3);
        clear(3'b110, 2'd3);
        steps(2);
        k = cyc;
        exp_ev(EV_COM, com_v(M_COM, 2'd3), k + 3);
        exp_tx(k + 3, 1, 3'b111);
        send(8'b101, 3);
        exp_ev(EV_COM, com_v(M_END, 2'd0), k + 4);
        @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        steps(2);
        rstN = 1'b1;
        steps(3);

        // Normal operation after reset.
        req(2'd1, 2'd2);
        clear(3'b110, 2'd1);
        steps(2);
        nak();
        steps(5);

        check("queues_drained", evq.size() + txq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
